// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
package multicycle_control_fsm_pkg;

  typedef enum logic [3:0] {
    ST_RST      = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_ALU_WB   = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_MEM_WB   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_LUI      = 4'd11,
    ST_TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALUOP_ARITH  = 3'd0;
  localparam logic [2:0] ALUOP_LOAD   = 3'd1;
  localparam logic [2:0] ALUOP_STORE  = 3'd2;
  localparam logic [2:0] ALUOP_BRANCH = 3'd3;
  localparam logic [2:0] ALUOP_LUI    = 3'd4;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  function automatic logic is_mem_state(state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Memory wait counter: counts mem_ready-low cycles, flags the cycle on which the limit is hit.
module multicycle_control_fsm_mem_wait_timer #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = (WAIT_LIMIT > 0) ? CNT_W'(WAIT_LIMIT - 1) : '0;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // Fires on the WAIT_LIMIT-th consecutive low cycle, as the count reaches the limit.
  assign expired = (WAIT_LIMIT > 0) && enable && (count == LAST);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback, traps on
// illegal opcodes and memory timeouts.
//
// state    | meaning
// RST      | post-reset idle, all strobes low
// FETCH    | read instruction at PC; on ready load IR and PC+4
// DECODE   | compute branch target into ALUOut, dispatch on op
// EXEC_R   | ALU rs1 op rs2
// EXEC_I   | ALU rs1 op imm
// ALU_WB   | write ALUOut to rd
// MEM_ADDR | compute effective address
// MEM_RD   | data read, wait for ready
// MEM_WB   | write MDR to rd
// MEM_WR   | data write, wait for ready
// BRANCH   | compare, conditional PC load from ALUOut
// LUI      | pass immediate, write rd
// TRAP     | absorbing error state
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int ALUOP_W    = 3,
  parameter int WAIT_LIMIT = 16,
  parameter int ENABLE_LUI = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               Branch,
  output logic               PCSource,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               MemToReg,
  output logic               RegWrite,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [3:0]         state_dbg
);

  state_t     state;
  logic       is_store;
  logic       in_mem;
  logic       wait_expired;
  logic [2:0] alu_code;
  logic       unused_zero;

  // zero only qualifies Branch in the external PC-load gate.
  assign unused_zero = zero;

  assign in_mem = is_mem_state(state);

  multicycle_control_fsm_mem_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_mem_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!in_mem || mem_ready),
    .enable (in_mem && !mem_ready),
    .expired(wait_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RST;
      is_store   <= 1'b0;
      trap       <= 1'b0;
      trap_cause <= CAUSE_NONE;
    end else begin
      case (state)
        ST_RST: state <= ST_FETCH;
        ST_FETCH: begin
          if (mem_ready) begin
            state <= ST_DECODE;
          end else if (wait_expired) begin
            state      <= ST_TRAP;
            trap       <= 1'b1;
            trap_cause <= CAUSE_TIMEOUT;
          end
        end
        ST_DECODE: begin
          is_store <= (op == OP_STORE);
          if (op == OP_R) begin
            state <= ST_EXEC_R;
          end else if (op == OP_I) begin
            state <= ST_EXEC_I;
          end else if (op == OP_LOAD || op == OP_STORE) begin
            state <= ST_MEM_ADDR;
          end else if (op == OP_BRANCH) begin
            state <= ST_BRANCH;
          end else if (op == OP_LUI && ENABLE_LUI != 0) begin
            state <= ST_LUI;
          end else begin
            state      <= ST_TRAP;
            trap       <= 1'b1;
            trap_cause <= CAUSE_ILLEGAL;
          end
        end
        ST_EXEC_R, ST_EXEC_I: state <= ST_ALU_WB;
        ST_MEM_ADDR: state <= is_store ? ST_MEM_WR : ST_MEM_RD;
        ST_MEM_RD: begin
          if (mem_ready) begin
            state <= ST_MEM_WB;
          end else if (wait_expired) begin
            state      <= ST_TRAP;
            trap       <= 1'b1;
            trap_cause <= CAUSE_TIMEOUT;
          end
        end
        ST_MEM_WR: begin
          if (mem_ready) begin
            state <= ST_FETCH;
          end else if (wait_expired) begin
            state      <= ST_TRAP;
            trap       <= 1'b1;
            trap_cause <= CAUSE_TIMEOUT;
          end
        end
        ST_ALU_WB, ST_MEM_WB, ST_BRANCH, ST_LUI: state <= ST_FETCH;
        ST_TRAP: state <= ST_TRAP;
        default: state <= ST_RST;
      endcase
    end
  end

  // Moore decode; IRWrite/PCWrite in FETCH are the only outputs qualified by mem_ready.
  always_comb begin
    mem_req  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    PCSource = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_RS2;
    alu_code = ALUOP_ARITH;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req  = 1'b1;
        MemRead  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        alu_code = ALUOP_LOAD;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
      end
      ST_DECODE: begin
        ALUSrcB  = SRCB_IMM;
        alu_code = ALUOP_BRANCH;
      end
      ST_EXEC_R: ALUSrcA = 1'b1;
      ST_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      ST_ALU_WB: RegWrite = 1'b1;
      ST_MEM_ADDR: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = SRCB_IMM;
        alu_code = is_store ? ALUOP_STORE : ALUOP_LOAD;
      end
      ST_MEM_RD: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      ST_MEM_WB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      ST_MEM_WR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      ST_BRANCH: begin
        ALUSrcA  = 1'b1;
        alu_code = ALUOP_BRANCH;
        Branch   = 1'b1;
        PCSource = 1'b1;
      end
      ST_LUI: begin
        ALUSrcB  = SRCB_IMM;
        alu_code = ALUOP_LUI;
        RegWrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign ALUOp     = ALUOP_W'(alu_code);
  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized self-checking bench for multicycle_control_fsm against an instruction-level model.
module tb_multicycle_control_fsm;
  import multicycle_control_fsm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic a_mem_req, a_IorD, a_MemRead, a_MemWrite, a_IRWrite, a_PCWrite, a_Branch;
  logic a_PCSource, a_ALUSrcA, a_MemToReg, a_RegWrite, a_trap;
  logic [1:0] a_ALUSrcB, a_trap_cause;
  logic [2:0] a_ALUOp;
  logic [3:0] a_state_dbg;
  logic b_mem_req, b_IorD, b_MemRead, b_MemWrite, b_IRWrite, b_PCWrite, b_Branch;
  logic b_PCSource, b_ALUSrcA, b_MemToReg, b_RegWrite, b_trap;
  logic [1:0] b_ALUSrcB, b_trap_cause;
  logic [2:0] b_ALUOp;
  logic [3:0] b_state_dbg;

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(a_mem_req), .IorD(a_IorD), .MemRead(a_MemRead), .MemWrite(a_MemWrite),
    .IRWrite(a_IRWrite), .PCWrite(a_PCWrite), .Branch(a_Branch), .PCSource(a_PCSource),
    .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB), .ALUOp(a_ALUOp), .MemToReg(a_MemToReg),
    .RegWrite(a_RegWrite), .trap(a_trap), .trap_cause(a_trap_cause), .state_dbg(a_state_dbg)
  );

  multicycle_control_fsm #(.ALUOP_W(3), .WAIT_LIMIT(4), .ENABLE_LUI(0)) dut_small (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .IorD(b_IorD), .MemRead(b_MemRead), .MemWrite(b_MemWrite),
    .IRWrite(b_IRWrite), .PCWrite(b_PCWrite), .Branch(b_Branch), .PCSource(b_PCSource),
    .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB), .ALUOp(b_ALUOp), .MemToReg(b_MemToReg),
    .RegWrite(b_RegWrite), .trap(b_trap), .trap_cause(b_trap_cause), .state_dbg(b_state_dbg)
  );

  always #5 clk = ~clk;

  // Observed vector; last bit is the effective PC load PCWrite | (Branch & zero).
  logic [23:0] obs_a, obs_b;
  assign obs_a = {a_state_dbg, a_trap, a_trap_cause, a_mem_req, a_IorD, a_MemRead, a_MemWrite,
                  a_IRWrite, a_PCWrite, a_Branch, a_PCSource, a_ALUSrcA, a_ALUSrcB, a_ALUOp,
                  a_MemToReg, a_RegWrite, a_PCWrite | (a_Branch & zero)};
  assign obs_b = {b_state_dbg, b_trap, b_trap_cause, b_mem_req, b_IorD, b_MemRead, b_MemWrite,
                  b_IRWrite, b_PCWrite, b_Branch, b_PCSource, b_ALUSrcA, b_ALUSrcB, b_ALUOp,
                  b_MemToReg, b_RegWrite, b_PCWrite | (b_Branch & zero)};

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [23:0] expv;
    logic        ready;
    logic [6:0]  op;
    logic        zero;
  } cyc_t;

  cyc_t q[$];

  localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BRANCH = 4, K_LUI = 5;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  // Expected control outputs for one cycle spent in a given phase of an instruction.
  function automatic logic [23:0] model(state_t st, logic rdy, logic zr, logic is_st,
                                        logic [1:0] cause);
    logic       req, iord, mr, mw, irw, pcw, br, pcs, sa, m2r, rw, tr;
    logic [1:0] sb, c;
    logic [2:0] ao;
    logic [3:0] s4;
    {req, iord, mr, mw, irw, pcw, br, pcs, sa, m2r, rw, tr} = '0;
    sb = 2'b00;
    c  = 2'b00;
    ao = 3'd0;
    s4 = st;
    case (st)
      ST_FETCH:    begin req = 1; mr = 1; sb = 2'b01; ao = 3'd1; irw = rdy; pcw = rdy; end
      ST_DECODE:   begin sb = 2'b10; ao = 3'd3; end
      ST_EXEC_R:   sa = 1;
      ST_EXEC_I:   begin sa = 1; sb = 2'b10; end
      ST_ALU_WB:   rw = 1;
      ST_MEM_ADDR: begin sa = 1; sb = 2'b10; ao = is_st ? 3'd2 : 3'd1; end
      ST_MEM_RD:   begin req = 1; mr = 1; iord = 1; end
      ST_MEM_WB:   begin rw = 1; m2r = 1; end
      ST_MEM_WR:   begin req = 1; mw = 1; iord = 1; end
      ST_BRANCH:   begin sa = 1; ao = 3'd3; br = 1; pcs = 1; end
      ST_LUI:      begin sb = 2'b10; ao = 3'd4; rw = 1; end
      ST_TRAP:     begin tr = 1; c = cause; end
      default: ;
    endcase
    return {s4, tr, c, req, iord, mr, mw, irw, pcw, br, pcs, sa, sb, ao, m2r, rw,
            pcw | (br & zr)};
  endfunction

  task automatic push(state_t st, logic rdy, logic [6:0] o, logic zr, logic is_st,
                      logic [1:0] cause);
    cyc_t e;
    e.expv  = model(st, rdy, zr, is_st, cause);
    e.ready = rdy;
    e.op    = o;
    e.zero  = zr;
    q.push_back(e);
  endtask

  // One instruction: wf fetch wait cycles, wm data wait cycles; don't-care inputs randomized.
  task automatic add_instr(int kind, int wf, int wm, logic zr);
    logic [6:0] opc;
    logic       st;
    st = (kind == K_STORE);
    case (kind)
      K_R:      opc = 7'b0110011;
      K_I:      opc = 7'b0010011;
      K_LOAD:   opc = 7'b0000011;
      K_STORE:  opc = 7'b0100011;
      K_BRANCH: opc = 7'b1100011;
      default:  opc = 7'b0110111;
    endcase
    for (int i = 0; i < wf; i++) push(ST_FETCH, 1'b0, rop(), rbit(), st, 2'b00);
    push(ST_FETCH, 1'b1, rop(), rbit(), st, 2'b00);
    push(ST_DECODE, rbit(), opc, rbit(), st, 2'b00);
    case (kind)
      K_R: begin
        push(ST_EXEC_R, rbit(), rop(), rbit(), st, 2'b00);
        push(ST_ALU_WB, rbit(), rop(), rbit(), st, 2'b00);
      end
      K_I: begin
        push(ST_EXEC_I, rbit(), rop(), rbit(), st, 2'b00);
        push(ST_ALU_WB, rbit(), rop(), rbit(), st, 2'b00);
      end
      K_LOAD: begin
        push(ST_MEM_ADDR, rbit(), rop(), rbit(), st, 2'b00);
        for (int i = 0; i < wm; i++) push(ST_MEM_RD, 1'b0, rop(), rbit(), st, 2'b00);
        push(ST_MEM_RD, 1'b1, rop(), rbit(), st, 2'b00);
        push(ST_MEM_WB, rbit(), rop(), rbit(), st, 2'b00);
      end
      K_STORE: begin
        push(ST_MEM_ADDR, rbit(), rop(), rbit(), st, 2'b00);
        for (int i = 0; i < wm; i++) push(ST_MEM_WR, 1'b0, rop(), rbit(), st, 2'b00);
        push(ST_MEM_WR, 1'b1, rop(), rbit(), st, 2'b00);
      end
      K_BRANCH: push(ST_BRANCH, rbit(), rop(), zr, st, 2'b00);
      default:  push(ST_LUI, rbit(), rop(), rbit(), st, 2'b00);
    endcase
  endtask

  // Drive each queued cycle at the falling edge, check just after, let the rising edge advance.
  task automatic run_queue(bit use_small, string name);
    cyc_t        e;
    logic [23:0] obs;
    int          n;
    n = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      mem_ready = e.ready;
      op        = e.op;
      zero      = e.zero;
      #1;
      obs = use_small ? obs_b : obs_a;
      tests++;
      if (obs !== e.expv) begin
        fails++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, n, obs, e.expv);
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    op = '0;
    zero = 1'b0;
    @(negedge clk);
    #1;
    tests++;
    if (obs_a !== 24'h0) begin
      fails++;
      $display("FAIL reset_outputs_a: got %h expected %h", obs_a, 24'h0);
    end
    tests++;
    if (obs_b !== 24'h0) begin
      fails++;
      $display("FAIL reset_outputs_b: got %h expected %h", obs_b, 24'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    push(ST_RST, rbit(), rop(), rbit(), 1'b0, 2'b00);
  endtask

  task automatic test_reset();
    do_reset();
    push(ST_FETCH, 1'b0, rop(), 1'b0, 1'b0, 2'b00);
    run_queue(1'b0, "reset_release");
  endtask

  task automatic test_r_type();
    do_reset();
    add_instr(K_R, 0, 0, 1'b0);
    add_instr(K_I, 0, 0, 1'b0);
    run_queue(1'b0, "r_then_i");
  endtask

  task automatic test_load_wait();
    do_reset();
    add_instr(K_LOAD, 0, 3, 1'b0);
    add_instr(K_STORE, 2, 2, 1'b0);
    push(ST_FETCH, 1'b0, rop(), 1'b0, 1'b0, 2'b00);
    run_queue(1'b0, "load_store_wait");
  endtask

  task automatic test_branch();
    do_reset();
    add_instr(K_BRANCH, 0, 0, 1'b1);
    add_instr(K_BRANCH, 0, 0, 1'b0);
    add_instr(K_LUI, 1, 0, 1'b0);
    push(ST_FETCH, 1'b0, rop(), 1'b0, 1'b0, 2'b00);
    run_queue(1'b0, "branch_lui");
  endtask

  task automatic test_illegal();
    do_reset();
    push(ST_FETCH, 1'b1, rop(), rbit(), 1'b0, 2'b00);
    push(ST_DECODE, rbit(), 7'b1111111, rbit(), 1'b0, 2'b00);
    for (int i = 0; i < 20; i++) push(ST_TRAP, rbit(), rop(), rbit(), 1'b0, 2'b01);
    run_queue(1'b0, "illegal_op");
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 4; i++) push(ST_FETCH, 1'b0, rop(), rbit(), 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) push(ST_TRAP, rbit(), rop(), rbit(), 1'b0, 2'b10);
    run_queue(1'b1, "timeout_trap");
    do_reset();
    add_instr(K_R, 3, 0, 1'b0);
    add_instr(K_LOAD, 0, 3, 1'b0);
    push(ST_FETCH, 1'b0, rop(), 1'b0, 1'b0, 2'b00);
    run_queue(1'b1, "ready_on_limit");
    do_reset();
    add_instr(K_STORE, 0, 0, 1'b0);
    push(ST_FETCH, 1'b1, rop(), rbit(), 1'b0, 2'b00);
    push(ST_DECODE, rbit(), 7'b0100011, rbit(), 1'b1, 2'b00);
    push(ST_MEM_ADDR, rbit(), rop(), rbit(), 1'b1, 2'b00);
    for (int i = 0; i < 4; i++) push(ST_MEM_WR, 1'b0, rop(), rbit(), 1'b1, 2'b00);
    push(ST_TRAP, 1'b1, rop(), rbit(), 1'b0, 2'b10);
    run_queue(1'b1, "write_timeout");
  endtask

  task automatic test_lui_disabled();
    do_reset();
    push(ST_FETCH, 1'b1, rop(), rbit(), 1'b0, 2'b00);
    push(ST_DECODE, rbit(), 7'b0110111, rbit(), 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) push(ST_TRAP, rbit(), rop(), rbit(), 1'b0, 2'b01);
    run_queue(1'b1, "lui_disabled");
  endtask

  task automatic test_reset_mid_write();
    logic [23:0] exp_wr;
    do_reset();
    push(ST_FETCH, 1'b1, rop(), 1'b0, 1'b0, 2'b00);
    push(ST_DECODE, 1'b0, 7'b0100011, 1'b0, 1'b1, 2'b00);
    push(ST_MEM_ADDR, 1'b0, rop(), 1'b0, 1'b1, 2'b00);
    push(ST_MEM_WR, 1'b0, rop(), 1'b0, 1'b1, 2'b00);
    run_queue(1'b0, "write_before_reset");
    mem_ready = 1'b0;
    zero = 1'b0;
    #2;
    exp_wr = model(ST_MEM_WR, 1'b0, 1'b0, 1'b1, 2'b00);
    tests++;
    if (obs_a !== exp_wr) begin
      fails++;
      $display("FAIL still_in_mem_wr: got %h expected %h", obs_a, exp_wr);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (obs_a !== 24'h0) begin
      fails++;
      $display("FAIL async_reset_mid_write: got %h expected %h", obs_a, 24'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push(ST_RST, rbit(), rop(), rbit(), 1'b0, 2'b00);
    add_instr(K_R, 0, 0, 1'b0);
    run_queue(1'b0, "after_mid_reset");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      add_instr($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3), rbit());
    end
    push(ST_FETCH, 1'b0, rop(), 1'b0, 1'b0, 2'b00);
    run_queue(1'b0, "random_stream");
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_load_wait();
    test_branch();
    test_illegal();
    test_timeout();
    test_lui_disabled();
    test_reset_mid_write();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
